ro_result_mailbox: RTL and testbench

//  Buffers result words from ro_toplevel (data_out/intr_out) and hands them to the PS one word per channel.

---
 rtl/ro_mailbox_pkg.sv | 17 +
 rtl/ro_mailbox_fifo.sv | 62 ++++++
 rtl/ro_result_mailbox.sv | 108 ++++++++++
 tb/tb_ro_result_mailbox.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_mailbox_pkg.sv
// Shared types and helpers for the result mailbox.
package ro_mailbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_GAP
  } state_t;

  localparam int TS_W = 16;

  // Pointer width: one extra bit separates full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ro_mailbox_fifo.sv
// Single-clock synchronous FIFO with registered read data.
// Push is accepted when not full, or when full and a pop happens in the same cycle.
module ro_mailbox_fifo
  import ro_mailbox_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_din,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level,
  output logic [WIDTH-1:0]       o_dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [PW-1:0]    w_level;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;
  logic             w_full, w_empty, w_do_push, w_do_pop;

  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_level == PW'(DEPTH));
  assign w_empty   = (w_level == '0);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Pointer update; wrap-around is natural modulo 2^PW.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  // Read register: loads only on pop, otherwise holds the last word.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)       r_dout <= '0;
    else if (w_do_pop) r_dout <= r_mem[r_rd_ptr[AW-1:0]];
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = w_level;
  assign o_dout  = r_dout;

endmodule

// File: rtl/ro_result_mailbox.sv
// Result mailbox: per-channel FIFO plus presentation FSM (IDLE/PRESENT/GAP).
// The FIFO read register doubles as the presented word, so rd_data holds its
// value through GAP and IDLE until the next pop.
// Optional feature: RO_MAILBOX_TSTAMP_EN adds a 16-bit push timestamp per word
// and the rd_tstamp output.
module ro_result_mailbox
  import ro_mailbox_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DEPTH  = 8,
  parameter int DW     = 32
) (
  input  logic                                 CLK,
  input  logic                                 RESETN,
  input  logic [NUM_CH-1:0]                    wr_strb,
  input  logic [NUM_CH*DW-1:0]                 wr_data,
  input  logic [NUM_CH-1:0]                    rd_ack,
  output logic [NUM_CH*DW-1:0]                 rd_data,
  output logic [NUM_CH-1:0]                    rd_intr,
  output logic [NUM_CH-1:0]                    ovf,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]  level
`ifdef RO_MAILBOX_TSTAMP_EN
  ,
  output logic [NUM_CH*TS_W-1:0]               rd_tstamp
`endif
);

  localparam int LW = ptr_w(DEPTH);

`ifdef RO_MAILBOX_TSTAMP_EN
  localparam int FW = DW + TS_W;
  logic [TS_W-1:0] r_tstamp;

  // Free-running cycle counter sampled at push.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_tstamp <= '0;
    else         r_tstamp <= r_tstamp + 1'b1;
  end
`else
  localparam int FW = DW;
`endif

  genvar c;
  for (c = 0; c < NUM_CH; c++) begin : g_ch
    state_t          r_state, w_state_nxt;
    logic            w_pop, w_full, w_empty;
    logic [LW-1:0]   w_level;
    logic [FW-1:0]   w_din, w_dout;
    logic            r_ovf;

`ifdef RO_MAILBOX_TSTAMP_EN
    assign w_din = {r_tstamp, wr_data[c*DW +: DW]};
    assign rd_tstamp[c*TS_W +: TS_W] = w_dout[FW-1 -: TS_W];
`else
    assign w_din = wr_data[c*DW +: DW];
`endif

    ro_mailbox_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
    ) u_fifo (
      .CLK     (CLK),
      .RESETN  (RESETN),
      .i_push  (wr_strb[c]),
      .i_din   (w_din),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level),
      .o_dout  (w_dout)
    );

    // Channel state register; reset forces IDLE so rd_intr drops at once.
    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
    end

    // Next state and pop: pop from IDLE, hold in PRESENT until ack, one GAP cycle.
    always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_PRESENT;
          end
        end
        ST_PRESENT: if (rd_ack[c]) w_state_nxt = ST_GAP;
        ST_GAP:     w_state_nxt = ST_IDLE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end

    // Sticky overflow: a strobe dropped because the FIFO is full and not popping.
    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN)                              r_ovf <= 1'b0;
      else if (wr_strb[c] && w_full && !w_pop)  r_ovf <= 1'b1;
    end

    assign rd_data[c*DW +: DW] = w_dout[DW-1:0];
    assign rd_intr[c]          = (r_state == ST_PRESENT);
    assign ovf[c]              = r_ovf;
    assign level[c*LW +: LW]   = w_level;
  end

endmodule

// File: tb/tb_ro_result_mailbox.sv
// Self-checking bench for ro_result_mailbox: vector table for single words,
// hand sequences for burst/overflow, full push+pop, spurious acks, mid-op reset.
module tb_ro_result_mailbox;

  localparam int NUM_CH = 3;
  localparam int DEPTH  = 8;
  localparam int DW     = 32;
  localparam int LW     = 4;

  logic                   CLK = 1'b0;
  logic                   RESETN;
  logic [NUM_CH-1:0]      wr_strb;
  logic [NUM_CH*DW-1:0]   wr_data;
  logic [NUM_CH-1:0]      rd_ack;
  logic [NUM_CH*DW-1:0]   rd_data;
  logic [NUM_CH-1:0]      rd_intr;
  logic [NUM_CH-1:0]      ovf;
  logic [NUM_CH*LW-1:0]   level;
`ifdef RO_MAILBOX_TSTAMP_EN
  logic [NUM_CH*16-1:0]   rd_tstamp;
`endif

  ro_result_mailbox #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DW(DW)) dut (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .wr_strb (wr_strb),
    .wr_data (wr_data),
    .rd_ack  (rd_ack),
    .rd_data (rd_data),
    .rd_intr (rd_intr),
    .ovf     (ovf),
    .level   (level)
`ifdef RO_MAILBOX_TSTAMP_EN
    ,
    .rd_tstamp (rd_tstamp)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q [NUM_CH][$];

  typedef struct {
    int          ch;
    logic [31:0] data;
    logic [2:0]  exp_intr;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rdd(input int c);
    return rd_data[c*DW +: DW];
  endfunction

  function automatic logic [LW-1:0] lvl(input int c);
    return level[c*LW +: LW];
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int c, input logic [31:0] d, input bit acc);
    wr_strb[c] = 1'b1;
    wr_data[c*DW +: DW] = d;
    if (acc) exp_q[c].push_back(d);
    step();
    wr_strb[c] = 1'b0;
  endtask

  task automatic ack(input int c);
    rd_ack[c] = 1'b1;
    step();
    rd_ack[c] = 1'b0;
  endtask

  task automatic wait_intr(input int c);
    int k = 0;
    while (!rd_intr[c] && k < 10) begin
      step();
      k++;
    end
    chk($sformatf("present_timeout_ch%0d", c), {63'd0, rd_intr[c]}, 64'd1);
  endtask

  task automatic present_chk(input int c);
    logic [31:0] e;
    if (exp_q[c].size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty_ch%0d: got %0h expected none", c, rdd(c));
    end else begin
      e = exp_q[c].pop_front();
      chk($sformatf("rd_data_ch%0d", c), {32'd0, rdd(c)}, {32'd0, e});
    end
  endtask

  task automatic drain(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      wait_intr(c);
      present_chk(c);
      ack(c);
      chk($sformatf("intr_after_ack_ch%0d", c), {63'd0, rd_intr[c]}, 64'd0);
    end
  endtask

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 32'hDEADBEEF, 3'b001};
    vecs[1] = '{1, 32'h12345678, 3'b010};
    vecs[2] = '{2, 32'hA5A5A5A5, 3'b100};
    vecs[3] = '{0, 32'h00000000, 3'b001};
    vecs[4] = '{2, 32'hFFFFFFFF, 3'b100};
    vecs[5] = '{1, 32'h80000001, 3'b010};

    RESETN  = 1'b0;
    wr_strb = '0;
    wr_data = '0;
    rd_ack  = '0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_intr", {61'd0, rd_intr}, 64'd0);
    chk("rst_ovf", {61'd0, ovf}, 64'd0);
    RESETN = 1'b1;
    step();
    chk("rst_level", {52'd0, level}, 64'd0);
    chk("rst_data", rd_data, 64'd0);
    chk("rst_data2", {32'd0, rd_data[95:64]}, 64'd0);

    // Single-word vectors on each channel
    foreach (vecs[i]) begin
      wr(vecs[i].ch, vecs[i].data, 1'b1);
      chk("vec_level_push", {60'd0, lvl(vecs[i].ch)}, 64'd1);
      chk("vec_intr_pre", {61'd0, rd_intr}, 64'd0);
      step();
      chk("vec_intr", {61'd0, rd_intr}, {61'd0, vecs[i].exp_intr});
      present_chk(vecs[i].ch);
      chk("vec_level_pres", {60'd0, lvl(vecs[i].ch)}, 64'd0);
      step();
      step();
      chk("vec_hold_data", {32'd0, rdd(vecs[i].ch)}, {32'd0, vecs[i].data});
      chk("vec_hold_intr", {61'd0, rd_intr}, {61'd0, vecs[i].exp_intr});
      ack(vecs[i].ch);
      chk("vec_intr_ack", {61'd0, rd_intr}, 64'd0);
      chk("vec_data_kept", {32'd0, rdd(vecs[i].ch)}, {32'd0, vecs[i].data});
      step();
      chk("vec_intr_idle", {61'd0, rd_intr}, 64'd0);
    end
    chk("vec_ovf", {61'd0, ovf}, 64'd0);

    // Burst on ch1: 8 words, 9th fills, 10th overflows
    for (int i = 1; i <= 8; i++) wr(1, 32'(i), 1'b1);
    chk("burst_level7", {60'd0, lvl(1)}, 64'd7);
    wr(1, 32'd9, 1'b1);
    chk("burst_level8", {60'd0, lvl(1)}, 64'd8);
    chk("burst_no_ovf", {63'd0, ovf[1]}, 64'd0);
    wr(1, 32'd10, 1'b0);
    chk("burst_ovf", {63'd0, ovf[1]}, 64'd1);
    chk("burst_level_ovf", {60'd0, lvl(1)}, 64'd8);
    drain(1, 9);
    chk("burst_q_empty", {32'd0, 32'(exp_q[1].size())}, 64'd0);
    chk("burst_level0", {60'd0, lvl(1)}, 64'd0);
    chk("burst_ovf_sticky", {63'd0, ovf[1]}, 64'd1);

    // Full ch2 with simultaneous pop and push
    for (int i = 0; i < 9; i++) wr(2, 32'h200 + 32'(i), 1'b1);
    chk("full_level8", {60'd0, lvl(2)}, 64'd8);
    wait_intr(2);
    present_chk(2);
    ack(2);
    step();
    chk("full_level_idle", {60'd0, lvl(2)}, 64'd8);
    wr(2, 32'hCAFE0002, 1'b1);
    chk("full_pushpop_level", {60'd0, lvl(2)}, 64'd8);
    chk("full_pushpop_ovf", {63'd0, ovf[2]}, 64'd0);
    chk("full_pushpop_intr", {63'd0, rd_intr[2]}, 64'd1);
    drain(2, 9);
    chk("full_q_empty", {32'd0, 32'(exp_q[2].size())}, 64'd0);

    // Spurious acks in IDLE and GAP on ch0
    ack(0);
    chk("spur_idle_intr", {63'd0, rd_intr[0]}, 64'd0);
    chk("spur_idle_level", {60'd0, lvl(0)}, 64'd0);
    wr(0, 32'h0000AAAA, 1'b1);
    wr(0, 32'h0000BBBB, 1'b1);
    chk("spur_level1", {60'd0, lvl(0)}, 64'd1);
    present_chk(0);
    ack(0);
    chk("gap_intr", {63'd0, rd_intr[0]}, 64'd0);
    chk("gap_level", {60'd0, lvl(0)}, 64'd1);
    rd_ack[0] = 1'b1;
    step();
    chk("spur_gap_intr", {63'd0, rd_intr[0]}, 64'd0);
    chk("spur_gap_level", {60'd0, lvl(0)}, 64'd1);
    step();
    rd_ack[0] = 1'b0;
    chk("idle_pop_intr", {63'd0, rd_intr[0]}, 64'd1);
    chk("idle_pop_level", {60'd0, lvl(0)}, 64'd0);
    present_chk(0);
    step();
    chk("spur_idle_ack_ignored", {63'd0, rd_intr[0]}, 64'd1);
    ack(0);
    chk("spur_final_intr", {63'd0, rd_intr[0]}, 64'd0);
    step();

    // Reset pulse mid-operation with ch0 presenting and level 3
    for (int i = 0; i < 4; i++) wr(0, 32'h300 + 32'(i), 1'b1);
    wait_intr(0);
    present_chk(0);
    chk("mid_level3", {60'd0, lvl(0)}, 64'd3);
    #2;
    RESETN = 1'b0;
    #1;
    chk("mid_rst_intr", {61'd0, rd_intr}, 64'd0);
    chk("mid_rst_level", {52'd0, level}, 64'd0);
    chk("mid_rst_ovf", {61'd0, ovf}, 64'd0);
    @(posedge CLK);
    #1;
    RESETN = 1'b1;
    exp_q[0].delete();
    step();
    step();
    step();
    chk("post_rst_intr", {61'd0, rd_intr}, 64'd0);
    chk("post_rst_level", {52'd0, level}, 64'd0);
    chk("post_rst_data", {32'd0, rdd(0)}, 64'd0);
    wr(0, 32'h00C0FFEE, 1'b1);
    step();
    chk("post_rst_present", {63'd0, rd_intr[0]}, 64'd1);
    present_chk(0);
    ack(0);
    step();
    chk("post_rst_level0", {60'd0, lvl(0)}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
